// File: rtl/param_stream_pkg.sv
// Shared types, constants and the beat checksum helper for the parameter stream sink.
package param_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } sink_state_t;

  localparam int CHECKSUM_WIDTH = 32;

  // Widest packed beat the checksum helper accepts; narrower beats are zero-padded.
  localparam int BEAT_SUM_MAX_W = 1024;

  // Sign-extend each elem_w-bit element of a packed beat and sum them modulo 2^32.
  function automatic logic [CHECKSUM_WIDTH-1:0] beat_sum(
    input logic [BEAT_SUM_MAX_W-1:0] beat,
    input int unsigned               elem_w,
    input int unsigned               n_elems
  );
    logic [CHECKSUM_WIDTH-1:0] acc;
    logic [CHECKSUM_WIDTH-1:0] mask;
    logic [CHECKSUM_WIDTH-1:0] elem;
    logic [BEAT_SUM_MAX_W-1:0] shifted;
    acc  = '0;
    mask = (32'h1 << elem_w) - 32'h1;
    for (int unsigned j = 0; j < n_elems; j++) begin
      shifted = beat >> (j * elem_w);
      elem    = shifted[CHECKSUM_WIDTH-1:0] & mask;
      if (elem[5'(elem_w - 32'd1)]) begin
        elem = elem | ~mask;
      end else begin
        elem = elem;
      end
      acc = acc + elem;
    end
    return acc;
  endfunction

endpackage

// File: rtl/param_stream_sink_if.sv
// Valid/ready parameter beat stream from the loader to the sink.
interface param_stream_sink_if #(
  parameter int PRECISION_0 = 16,
  parameter int BEAT_ELEMS  = 1
);
  logic [PRECISION_0-1:0] data_in [BEAT_ELEMS];
  logic                   data_in_valid;
  logic                   data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/param_stream_buffer.sv
// Simple dual-port parameter RAM: one write port, read port with two ce-gated
// registered stages matching the generated parameter ROMs. Reads are read-first.
module param_stream_buffer #(
  parameter  int DEPTH = 32,
  parameter  int DW    = 16,
  localparam int AW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_ce,
  output logic [DW-1:0] rd_data
);
  // The array spans the whole address range so every rd_addr indexes a real
  // entry; entries at DEPTH and above are never written.
  localparam int SLOTS = 2 ** AW;

  logic [DW-1:0] mem_r [SLOTS];
  logic [DW-1:0] stage0_r;
  logic [DW-1:0] rd_data_r;

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Two-stage read pipeline; both stages move only on rd_ce, old word on collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage0_r  <= '0;
      rd_data_r <= '0;
    end else if (rd_ce) begin
      stage0_r  <= mem_r[rd_addr];
      rd_data_r <= stage0_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/param_stream_sink.sv
// Parameter stream sink: loads one tensor of beats into a buffer at run time and
// serves it through a ROM-compatible 2-stage read port.
module param_stream_sink
  import param_stream_pkg::*;
#(
  parameter  int PRECISION_0       = 16,
  parameter  int PRECISION_1       = 3,
  parameter  int TENSOR_SIZE_DIM_0 = 32,
  parameter  int PARALLELISM_DIM_0 = 1,
  parameter  int PARALLELISM_DIM_1 = 1,
  localparam int BEAT_ELEMS        = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
  localparam int DEPTH             = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
  localparam int CW                = $clog2(DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  param_stream_sink_if.slave                s_in,
  output logic                              load_done,
  output logic [CW-1:0]                     beat_count,
  output logic [CHECKSUM_WIDTH-1:0]         checksum,
  input  logic [CW-1:0]                     rd_addr,
  input  logic                              rd_ce,
  output logic [PRECISION_0*BEAT_ELEMS-1:0] rd_data
);
  localparam int BEAT_W = PRECISION_0 * BEAT_ELEMS;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_DONE = DONE;

  // Fractional bits only travel with the data format; storage never depends on them.
  if (PRECISION_1 >= PRECISION_0) begin : g_frac_wider_than_element
  end

  logic [1:0]                state_r;
  logic [1:0]                state_next_s;
  logic                      load_done_r;
  logic [CW-1:0]             beat_count_r;
  logic [CHECKSUM_WIDTH-1:0] checksum_r;
  logic [BEAT_W-1:0]         beat_s;
  logic [BEAT_SUM_MAX_W-1:0] beat_wide_s;
  logic [CHECKSUM_WIDTH-1:0] beat_sum_s;
  logic                      ready_s;
  logic                      accept_s;
  logic                      last_beat_s;

  assign ready_s     = (state_r == ST_LOAD);
  assign accept_s    = s_in.data_in_valid && ready_s && !start;
  assign last_beat_s = (beat_count_r == CW'(DEPTH - 1));

  // Pack the unpacked beat (element j at bits j*PRECISION_0) and compute its signed sum.
  always_comb begin
    beat_s      = '0;
    beat_wide_s = '0;
    for (int j = 0; j < BEAT_ELEMS; j++) begin
      beat_s[PRECISION_0*j +: PRECISION_0] = s_in.data_in[j];
    end
    beat_wide_s[BEAT_W-1:0] = beat_s;
    beat_sum_s = beat_sum(beat_wide_s, PRECISION_0, BEAT_ELEMS);
  end

  // Next-state logic; start always (re)enters LOAD, including mid-load aborts.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_LOAD;
        else       state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (start)                        state_next_s = ST_LOAD;
        else if (accept_s && last_beat_s) state_next_s = ST_DONE;
        else                              state_next_s = ST_LOAD;
      end
      ST_DONE: begin
        if (start) state_next_s = ST_LOAD;
        else       state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, load_done, beat counter and running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      load_done_r  <= 1'b0;
      beat_count_r <= '0;
      checksum_r   <= '0;
    end else begin
      state_r     <= state_next_s;
      load_done_r <= (state_next_s == ST_DONE);
      if (start) begin
        beat_count_r <= '0;
        checksum_r   <= '0;
      end else if (accept_s) begin
        beat_count_r <= beat_count_r + CW'(1);
        checksum_r   <= checksum_r + beat_sum_s;
      end else begin
        beat_count_r <= beat_count_r;
        checksum_r   <= checksum_r;
      end
    end
  end

  param_stream_buffer #(
    .DEPTH (DEPTH),
    .DW    (BEAT_W)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_s),
    .wr_addr (beat_count_r),
    .wr_data (beat_s),
    .rd_addr (rd_addr),
    .rd_ce   (rd_ce),
    .rd_data (rd_data)
  );

  assign s_in.data_in_ready = ready_s;
  assign load_done          = load_done_r;
  assign beat_count         = beat_count_r;
  assign checksum           = checksum_r;

endmodule

// File: tb/tb_param_stream_sink.sv
// Directed self-checking bench for param_stream_sink (default parameters, DEPTH=32).
module tb_param_stream_sink;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  rd_addr;
  logic        rd_ce;
  logic        load_done;
  logic [5:0]  beat_count;
  logic [31:0] checksum;
  logic [15:0] rd_data;

  int n_checks;
  int n_pass;

  param_stream_sink_if #(.PRECISION_0(16), .BEAT_ELEMS(1)) s_if ();

  param_stream_sink dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_in       (s_if.slave),
    .load_done  (load_done),
    .beat_count (beat_count),
    .checksum   (checksum),
    .rd_addr    (rd_addr),
    .rd_ce      (rd_ce),
    .rd_data    (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic read_word(input logic [5:0] addr, output logic [15:0] d);
    rd_ce   = 1'b1;
    rd_addr = addr;
    tick();
    tick();
    d = rd_data;
  endtask

  task automatic test_reset();
    s_if.data_in_valid = 1'b1;
    s_if.data_in[0]    = 16'h5555;
    tick(); tick(); tick();
    n_checks++; if (s_if.data_in_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", s_if.data_in_ready); else n_pass++;
    n_checks++; if (beat_count !== 6'd0) $display("FAIL reset_count got %0d want 0", beat_count); else n_pass++;
    n_checks++; if (checksum !== 32'd0) $display("FAIL reset_checksum got %h want 0", checksum); else n_pass++;
    n_checks++; if (rd_data !== 16'd0) $display("FAIL reset_rd_data got %h want 0", rd_data); else n_pass++;
    n_checks++; if (load_done !== 1'b0) $display("FAIL reset_done got %b want 0", load_done); else n_pass++;
    s_if.data_in_valid = 1'b0;
  endtask

  task automatic test_full_load();
    start_load();
    n_checks++; if (s_if.data_in_ready !== 1'b1) $display("FAIL full_ready_rise got %b want 1", s_if.data_in_ready); else n_pass++;
    for (int k = 0; k < 32; k++) begin
      s_if.data_in[0]    = 16'(k + 1);
      s_if.data_in_valid = 1'b1;
      tick();
      if (k == 30) begin
        n_checks++; if (load_done !== 1'b0 || beat_count !== 6'd31) $display("FAIL full_before_last done=%b count=%0d want 0/31", load_done, beat_count); else n_pass++;
      end
    end
    n_checks++; if (load_done !== 1'b1) $display("FAIL full_done got %b want 1", load_done); else n_pass++;
    n_checks++; if (s_if.data_in_ready !== 1'b0) $display("FAIL full_ready_fall got %b want 0", s_if.data_in_ready); else n_pass++;
    n_checks++; if (beat_count !== 6'd32) $display("FAIL full_count got %0d want 32", beat_count); else n_pass++;
    n_checks++; if (checksum !== 32'd528) $display("FAIL full_checksum got %0d want 528", checksum); else n_pass++;
    s_if.data_in[0] = 16'h9999;
    tick(); tick(); tick();
    n_checks++; if (beat_count !== 6'd32) $display("FAIL full_overrun_count got %0d want 32", beat_count); else n_pass++;
    s_if.data_in_valid = 1'b0;
    // Streamed readback: address i presented before edge i shows up after edge i+1.
    rd_ce = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      rd_addr = (i < 32) ? 6'(i) : 6'd0;
      tick();
      if (i >= 1) begin
        n_checks++; if (rd_data !== 16'(i)) $display("FAIL full_readback addr %0d got %h want %h", i - 1, rd_data, 16'(i)); else n_pass++;
      end
    end
    // rd_ce low freezes both stages: rd_data keeps word 31, stage0 keeps word 0.
    rd_ce   = 1'b0;
    rd_addr = 6'd7;
    tick(); tick();
    n_checks++; if (rd_data !== 16'd32) $display("FAIL ce_hold_out got %h want 0020", rd_data); else n_pass++;
    rd_ce = 1'b1;
    tick();
    n_checks++; if (rd_data !== 16'd1) $display("FAIL ce_hold_stage0 got %h want 0001", rd_data); else n_pass++;
    rd_ce = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] d;
    start_load();
    for (int k = 0; k < 10; k++) begin
      s_if.data_in[0]    = 16'(100 + k);
      s_if.data_in_valid = 1'b1;
      tick();
    end
    n_checks++; if (beat_count !== 6'd10) $display("FAIL abort_pre_count got %0d want 10", beat_count); else n_pass++;
    start              = 1'b1;
    s_if.data_in[0]    = 16'h7777;
    s_if.data_in_valid = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (beat_count !== 6'd0) $display("FAIL abort_count got %0d want 0", beat_count); else n_pass++;
    n_checks++; if (checksum !== 32'd0) $display("FAIL abort_checksum got %h want 0", checksum); else n_pass++;
    n_checks++; if (s_if.data_in_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", s_if.data_in_ready); else n_pass++;
    for (int k = 0; k < 32; k++) begin
      s_if.data_in[0] = 16'hFFFF;
      tick();
    end
    s_if.data_in_valid = 1'b0;
    n_checks++; if (beat_count !== 6'd32) $display("FAIL abort_final_count got %0d want 32", beat_count); else n_pass++;
    n_checks++; if (load_done !== 1'b1) $display("FAIL abort_done got %b want 1", load_done); else n_pass++;
    n_checks++; if (checksum !== 32'hFFFF_FFE0) $display("FAIL abort_checksum_final got %h want ffffffe0", checksum); else n_pass++;
    for (int a = 0; a < 32; a++) begin
      read_word(6'(a), d);
      n_checks++; if (d !== 16'hFFFF) $display("FAIL abort_readback addr %0d got %h want ffff", a, d); else n_pass++;
    end
    rd_ce = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] pattern;
    logic [15:0] d;
    int          exp_count;
    int          cyc;
    pattern   = 16'b1011_0010_1110_0101;
    exp_count = 0;
    cyc       = 0;
    start_load();
    while (exp_count < 32 && cyc < 400) begin
      if (pattern[cyc % 16]) begin
        s_if.data_in_valid = 1'b1;
        s_if.data_in[0]    = 16'(exp_count + 1);
      end else begin
        s_if.data_in_valid = 1'b0;
        s_if.data_in[0]    = 16'hDEAD;
      end
      tick();
      if (pattern[cyc % 16]) exp_count++;
      cyc++;
    end
    s_if.data_in_valid = 1'b0;
    n_checks++; if (cyc >= 400) $display("FAIL bp_timeout cycles %0d limit 400", cyc); else n_pass++;
    n_checks++; if (beat_count !== 6'd32) $display("FAIL bp_count got %0d want 32", beat_count); else n_pass++;
    n_checks++; if (load_done !== 1'b1) $display("FAIL bp_done got %b want 1", load_done); else n_pass++;
    n_checks++; if (checksum !== 32'd528) $display("FAIL bp_checksum got %0d want 528", checksum); else n_pass++;
    for (int a = 0; a < 32; a++) begin
      read_word(6'(a), d);
      n_checks++; if (d !== 16'(a + 1)) $display("FAIL bp_readback addr %0d got %h want %h", a, d, 16'(a + 1)); else n_pass++;
    end
    rd_ce = 1'b0;
  endtask

  task automatic test_collision();
    // Buffer holds 1..32 from the previous load, so word 5 is 6 before this load.
    rd_ce   = 1'b1;
    rd_addr = 6'd5;
    start_load();
    for (int k = 0; k < 32; k++) begin
      s_if.data_in[0]    = (k == 5) ? 16'h1234 : 16'(16'h0A00 + k);
      s_if.data_in_valid = 1'b1;
      tick();
      if (k == 6) begin
        n_checks++; if (rd_data !== 16'd6) $display("FAIL collision_old got %h want 0006", rd_data); else n_pass++;
      end
      if (k == 7) begin
        n_checks++; if (rd_data !== 16'h1234) $display("FAIL collision_new got %h want 1234", rd_data); else n_pass++;
      end
    end
    s_if.data_in_valid = 1'b0;
    rd_ce = 1'b0;
    n_checks++; if (checksum !== 32'd84511) $display("FAIL collision_checksum got %0d want 84511", checksum); else n_pass++;
    n_checks++; if (beat_count !== 6'd32) $display("FAIL collision_count got %0d want 32", beat_count); else n_pass++;
  endtask

  task automatic test_done_sticky();
    logic [15:0] d;
    s_if.data_in_valid = 1'b1;
    s_if.data_in[0]    = 16'hBEEF;
    for (int c = 0; c < 10; c++) tick();
    s_if.data_in_valid = 1'b0;
    n_checks++; if (beat_count !== 6'd32) $display("FAIL sticky_count got %0d want 32", beat_count); else n_pass++;
    n_checks++; if (s_if.data_in_ready !== 1'b0) $display("FAIL sticky_ready got %b want 0", s_if.data_in_ready); else n_pass++;
    n_checks++; if (load_done !== 1'b1) $display("FAIL sticky_done got %b want 1", load_done); else n_pass++;
    n_checks++; if (checksum !== 32'd84511) $display("FAIL sticky_checksum got %0d want 84511", checksum); else n_pass++;
    read_word(6'd0, d);
    n_checks++; if (d !== 16'h0A00) $display("FAIL sticky_word0 got %h want 0a00", d); else n_pass++;
    read_word(6'd5, d);
    n_checks++; if (d !== 16'h1234) $display("FAIL sticky_word5 got %h want 1234", d); else n_pass++;
    read_word(6'd31, d);
    n_checks++; if (d !== 16'h0A1F) $display("FAIL sticky_word31 got %h want 0a1f", d); else n_pass++;
    rd_ce = 1'b0;
    // Reload with negative elements -16-k: sum is -1008.
    start_load();
    n_checks++; if (load_done !== 1'b0) $display("FAIL reload_done_clear got %b want 0", load_done); else n_pass++;
    for (int k = 0; k < 32; k++) begin
      s_if.data_in[0]    = 16'(16'hFFF0 - k);
      s_if.data_in_valid = 1'b1;
      tick();
    end
    s_if.data_in_valid = 1'b0;
    n_checks++; if (checksum !== 32'hFFFF_FC10) $display("FAIL reload_checksum got %h want fffffc10", checksum); else n_pass++;
    n_checks++; if (beat_count !== 6'd32) $display("FAIL reload_count got %0d want 32", beat_count); else n_pass++;
    read_word(6'd0, d);
    n_checks++; if (d !== 16'hFFF0) $display("FAIL reload_word0 got %h want fff0", d); else n_pass++;
    read_word(6'd5, d);
    n_checks++; if (d !== 16'hFFEB) $display("FAIL reload_word5 got %h want ffeb", d); else n_pass++;
    read_word(6'd31, d);
    n_checks++; if (d !== 16'hFFD1) $display("FAIL reload_word31 got %h want ffd1", d); else n_pass++;
    rd_ce = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int k = 0; k < 5; k++) begin
      s_if.data_in[0]    = 16'(k + 3);
      s_if.data_in_valid = 1'b1;
      tick();
    end
    n_checks++; if (beat_count !== 6'd5) $display("FAIL midrst_pre_count got %0d want 5", beat_count); else n_pass++;
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst                = 1'b0;
    start              = 1'b0;
    s_if.data_in_valid = 1'b0;
    n_checks++; if (s_if.data_in_ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", s_if.data_in_ready); else n_pass++;
    n_checks++; if (load_done !== 1'b0) $display("FAIL midrst_done got %b want 0", load_done); else n_pass++;
    n_checks++; if (beat_count !== 6'd0) $display("FAIL midrst_count got %0d want 0", beat_count); else n_pass++;
    n_checks++; if (checksum !== 32'd0) $display("FAIL midrst_checksum got %h want 0", checksum); else n_pass++;
    n_checks++; if (rd_data !== 16'd0) $display("FAIL midrst_rd_data got %h want 0", rd_data); else n_pass++;
    tick();
    n_checks++; if (s_if.data_in_ready !== 1'b0) $display("FAIL midrst_start_ignored ready %b want 0", s_if.data_in_ready); else n_pass++;
  endtask

  initial begin
    n_checks           = 0;
    n_pass             = 0;
    rst                = 1'b1;
    start              = 1'b0;
    rd_addr            = 6'd0;
    rd_ce              = 1'b0;
    s_if.data_in_valid = 1'b0;
    s_if.data_in[0]    = 16'd0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_full_load();
    test_abort();
    test_backpressure();
    test_collision();
    test_done_sticky();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
